// File: rtl/eight_bit_pkg.sv
// Shared types and sizing constants for the 8-bit CPU program-loading path.
package eight_bit_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } loader_state_t;

    localparam int RAM_DEPTH  = 16;
    localparam int RAM_ADDR_W = 4;
    localparam int BUS_W      = 8;

endpackage

// File: rtl/prog_loader.sv
// Streams DEPTH bytes into the program RAM, verifies a trailing checksum byte,
// and only releases the CPU once the whole image checks out.
module prog_loader
    import eight_bit_pkg::*;
#(
    parameter int DEPTH  = RAM_DEPTH,
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = BUS_W
) (
    input  logic              fastClk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              prog_mode,
    output logic              cpu_run,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   byte_count
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DEPTH - 1);

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              prog_mode_q, prog_mode_d;
    logic              cpu_run_q, cpu_run_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              xfer_s;
    logic [DATA_W-1:0] sum_s;

    // Abort blocks the handshake in the same cycle so no byte is lost mid-abort.
    assign in_ready = ((state_q == LOAD) || (state_q == CHECK)) && !abort;
    assign xfer_s   = in_valid && in_ready;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        count_d     = count_q;
        acc_d       = acc_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        sum_s       = acc_q + in_data;

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state_d = LOAD;
                        addr_d  = {ADDR_W{1'b0}};
                        count_d = {CNT_W{1'b0}};
                        acc_d   = {DATA_W{1'b0}};
                    end else begin
                        state_d = state_q;
                    end
                end
                LOAD: begin
                    if (xfer_s) begin
                        ram_we_d    = 1'b1;
                        ram_addr_d  = addr_q;
                        ram_wdata_d = in_data;
                        addr_d      = addr_q + ADDR_W'(1);
                        count_d     = count_q + CNT_W'(1);
                        acc_d       = sum_s;
                        if (count_q == LAST_DATA) begin
                            state_d = CHECK;
                        end else begin
                            state_d = LOAD;
                        end
                    end else begin
                        state_d = LOAD;
                    end
                end
                CHECK: begin
                    // The checksum byte is never written; it must bring the sum to zero.
                    if (xfer_s) begin
                        if (sum_s == {DATA_W{1'b0}}) begin
                            state_d = DONE;
                        end else begin
                            state_d = ERR;
                        end
                    end else begin
                        state_d = CHECK;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        prog_mode_d = (state_d != DONE);
        cpu_run_d   = (state_d == DONE);
        done_d      = (state_d == DONE);
        err_d       = (state_d == ERR);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge fastClk) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= {ADDR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            acc_q       <= {DATA_W{1'b0}};
            ram_we_q    <= 1'b0;
            ram_addr_q  <= {ADDR_W{1'b0}};
            ram_wdata_q <= {DATA_W{1'b0}};
            prog_mode_q <= 1'b1;
            cpu_run_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            prog_mode_q <= prog_mode_d;
            cpu_run_q   <= cpu_run_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign prog_mode  = prog_mode_q;
    assign cpu_run    = cpu_run_q;
    assign done       = done_q;
    assign err        = err_q;
    assign byte_count = count_q;

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader that fills the 16×8 program RAM from an external valid/ready source, verifies a trailing checksum, and only then releases the CPU to run. It sits between the chip's input pins and the RAM's programming port. While loading or after a failed load, it holds the CPU in program mode. It replaces manual address/data toggling of the RAM with a single start-and-stream sequence.

## Interface
Parameters:
- DEPTH, 16: number of RAM words loaded; must equal 2**ADDR_W.
- ADDR_W, 4: RAM address width.
- DATA_W, 8: byte width.

Ports:
- fastClk  in  1  single clock; every register is clocked on its rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  begin a load; sampled in IDLE, DONE and ERR, ignored in LOAD and CHECK.
- abort  in  1  return to IDLE; highest priority after reset.
- in_valid  in  1  source has a byte on in_data.
- in_data  in  DATA_W  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- ram_we  out  1  one-cycle RAM write strobe.
- ram_addr  out  ADDR_W  RAM write address.
- ram_wdata  out  DATA_W  RAM write data.
- prog_mode  out  1  1 = CPU held in program mode.
- cpu_run  out  1  1 = program verified, CPU may clock.
- done  out  1  level; high in DONE.
- err  out  1  level; high in ERR.
- byte_count  out  ADDR_W+1  data bytes accepted in the current load (0..DEPTH).

## Operation
- The state machine has five states: IDLE, LOAD, CHECK, DONE and ERR.
- Transfer rule: a byte transfers on a cycle where in_valid && in_ready are both high.
- in_ready is asserted in LOAD and CHECK only, and is forced low whenever abort=1.
- IDLE: prog_mode=1, cpu_run=0. On start, clear the address, byte_count and checksum accumulator, then go to LOAD.
- LOAD: each transfer does the following:
  - registers ram_addr ← current address and ram_wdata ← in_data;
  - pulses ram_we on the next cycle;
  - increments the address and byte_count;
  - adds in_data to the 8-bit accumulator, mod 256.
- The transfer that makes byte_count equal DEPTH moves the machine to CHECK. The address wraps 15→0 at that point and is not used again.
- CHECK: exactly one more byte is accepted. This byte is the checksum; it is not written to RAM.
  - If (accumulator + byte) mod 256 == 0, go to DONE; otherwise go to ERR.
- DONE: prog_mode=0, cpu_run=1, done=1. A start here begins a reload: go to LOAD and drop cpu_run.
- ERR: prog_mode=1, cpu_run=0, err=1. A start here retries the load.
- abort: from any state, go to IDLE on the next cycle.
  - A ram_we already scheduled by a transfer in the previous cycle still completes; writes are never truncated.
  - No new transfer occurs in the abort cycle.
- in_valid outside LOAD and CHECK is ignored and in_data is not consumed.
- Simultaneous start and abort: abort wins.

## Timing
- Reset (rst=0 at an edge) sets:
  - state=IDLE;
  - prog_mode=1, cpu_run=0, done=0, err=0;
  - in_ready=0, ram_we=0, ram_addr=0, ram_wdata=0;
  - byte_count=0, accumulator=0.
- A reset mid-load also discards any pending write.
- start sampled at edge N: LOAD is active and in_ready=1 after edge N.
- A transfer at edge T produces ram_we=1 with matching ram_addr/ram_wdata during the cycle after T. Write latency is 1 cycle.
- Back-to-back transfers are allowed, giving one write per cycle. Throughput is 1 byte per clock.
- The 16th data transfer at edge T gives state=CHECK after T. in_ready stays high, so the checksum may be accepted at T+1.
- Checksum accepted at edge M: state is DONE or ERR after M, and cpu_run/done/err become valid in that same cycle.
- The last RAM write pulse precedes the checksum cycle, so cpu_run never rises before all 16 writes have completed.
- All outputs are registered except in_ready, which is a decode of the registered state and abort.

## Structure
- Shared package eight_bit_pkg holds:
  - the loader_state_t enum {IDLE, LOAD, CHECK, DONE, ERR};
  - the constants RAM_DEPTH=16, RAM_ADDR_W=4, BUS_W=8.
- Single module. The checksum accumulator and write-staging registers are inline, so no sub-module is needed.

## Test plan
- Reset/idle: hold rst=0 for 2 cycles, then release → prog_mode=1, cpu_run=0, in_ready=0, ram_we=0, byte_count=0.
- Good load: pulse start, then stream bytes 0x00..0x0F back-to-back followed by checksum 0x88 → 16 ram_we pulses at addr 0..15 with data 0x00..0x0F, then DONE: cpu_run=1, prog_mode=0, done=1.
- Bad checksum: same stream with checksum 0x89 → ERR: err=1, prog_mode=1, cpu_run=0; a new start and a correct stream then reach DONE.
- Gapped source: toggle in_valid pseudo-randomly during the good load → identical write sequence; byte_count tracks transfers only.
- Abort after 5 transfers, with the 5th transfer in the previous cycle → the write at addr 4 still pulses, state goes to IDLE, no further writes occur, and byte_count=0 after the restart.
- Mid-load reset: assert rst=0 after 9 bytes → all outputs return to their reset values and the pending write is dropped. A start with abort held high in IDLE has no effect.
